md_stall_ctrl: RTL and testbench

//   Parametrised multi-cycle stall controller for the multiply/divide unit.

---
 rtl/md_stall_pkg.sv | 16 +
 rtl/md_down_counter.sv | 42 ++++
 rtl/md_stall_ctrl.sv | 123 ++++++++++++
 tb/tb_md_stall_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_stall_pkg.sv
// Shared types and default constants for the multiply/divide stall controller.
package md_stall_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } md_state_e;

    // Default configuration
    localparam int unsigned CntWDefault   = 6;
    localparam int unsigned MulLatDefault = 32;
    localparam int unsigned DivLatDefault = 32;

endpackage

// File: rtl/md_down_counter.sv
// Loadable down-counter that saturates at zero.
// Priority: synchronous clear, then load, then decrement.
module md_down_counter #(
    parameter int unsigned W = 6
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] count_q, count_d;

    // Next count: decrement is gated off at zero so the counter never wraps
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/md_stall_ctrl.sv
// Multi-cycle stall controller for the multiply/divide unit.
// Holds stall for MulLat/DivLat cycles per op and pulses result_ready_o on completion.
// Optional feature macro MD_STALL_RESTART_EN: a start while busy restarts the stall
// with the new op's latency; when undefined such a start is ignored.
module md_stall_ctrl
    import md_stall_pkg::*;
#(
    parameter int unsigned CntW   = CntWDefault,
    parameter int unsigned MulLat = MulLatDefault,
    parameter int unsigned DivLat = DivLatDefault
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_mul_i,
    input  logic            start_div_i,
    input  logic            kill_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            result_ready_o,
    output logic            op_is_div_o,
    output logic [CntW-1:0] cycles_left_o
);

    // Counter holds remaining stall cycles minus one
    localparam logic [CntW-1:0] MulLoad = CntW'(MulLat - 1);
    localparam logic [CntW-1:0] DivLoad = CntW'(DivLat - 1);

    md_state_e       state_q, state_d;
    logic            op_div_q, op_div_d;
    logic            start_any;
    logic [CntW-1:0] sel_load;
    logic            cnt_clr, cnt_load, cnt_dec, cnt_zero;
    logic [CntW-1:0] cnt_val;

    // Multiply wins when both strobes arrive together
    assign start_any = start_mul_i | start_div_i;
    assign sel_load  = start_mul_i ? MulLoad : DivLoad;

    md_down_counter #(
        .W (CntW)
    ) u_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (sel_load),
        .dec_i      (cnt_dec),
        .count_o    (cnt_val),
        .zero_o     (cnt_zero)
    );

    // Next-state, counter control and op-type capture; kill beats everything
    always_comb begin
        state_d  = state_q;
        op_div_d = op_div_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!kill_i && start_any) begin
                    state_d  = StBusy;
                    cnt_load = 1'b1;
                    op_div_d = ~start_mul_i;
                end
            end
            StBusy: begin
                if (kill_i) begin
                    state_d = StIdle;
                    cnt_clr = 1'b1;
                end
`ifdef MD_STALL_RESTART_EN
                else if (start_any) begin
                    cnt_load = 1'b1;
                    op_div_d = ~start_mul_i;
                end
`endif
                else if (cnt_zero) begin
                    state_d = StDone;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StDone: begin
                if (kill_i) begin
                    state_d = StIdle;
                    cnt_clr = 1'b1;
                end else if (start_any) begin
                    state_d  = StBusy;
                    cnt_load = 1'b1;
                    op_div_d = ~start_mul_i;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // State and op-type registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            op_div_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_div_q <= op_div_d;
        end
    end

    // Output decode
    always_comb begin
        stall_o        = (state_q == StBusy);
        busy_o         = (state_q == StBusy);
        result_ready_o = (state_q == StDone);
        op_is_div_o    = op_div_q;
        cycles_left_o  = cnt_val;
    end

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Scoreboard bench for md_stall_ctrl: a cycle-count reference model predicts each
// cycle's outputs, a monitor pops and compares them on the falling edge.
module tb_md_stall_ctrl;

    localparam int unsigned CNT_W   = 6;
    localparam int unsigned MUL_LAT = 32;
    localparam int unsigned DIV_LAT = 4;
`ifdef MD_STALL_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_mul = 1'b0;
    logic             start_div = 1'b0;
    logic             kill = 1'b0;
    logic             stall, busy, result_ready, op_is_div;
    logic [CNT_W-1:0] cycles_left;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct {
        bit stall;
        bit rr;
        bit opdiv;
        int cl;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: stall cycles still to go, pending completion, last op type
    int m_rem   = 0;
    bit m_done  = 1'b0;
    bit m_opdiv = 1'b0;

    md_stall_ctrl #(
        .CntW   (CNT_W),
        .MulLat (MUL_LAT),
        .DivLat (DIV_LAT)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_mul_i    (start_mul),
        .start_div_i    (start_div),
        .kill_i         (kill),
        .stall_o        (stall),
        .busy_o         (busy),
        .result_ready_o (result_ready),
        .op_is_div_o    (op_is_div),
        .cycles_left_o  (cycles_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.stall = (m_rem > 0);
        e.rr    = m_done;
        e.opdiv = m_opdiv;
        e.cl    = (m_rem > 0) ? m_rem - 1 : 0;
        return e;
    endfunction

    // Advance the model across one rising edge with the given inputs
    task automatic model_edge(input bit sm, input bit sd, input bit k);
        if (k) begin
            m_rem  = 0;
            m_done = 1'b0;
        end else if (m_rem > 0) begin
            if (RESTART && (sm || sd)) begin
                m_rem   = sm ? int'(MUL_LAT) : int'(DIV_LAT);
                m_opdiv = !sm;
            end else begin
                m_rem  = m_rem - 1;
                m_done = (m_rem == 0);
            end
        end else begin
            m_done = 1'b0;
            if (sm || sd) begin
                m_rem   = sm ? int'(MUL_LAT) : int'(DIV_LAT);
                m_opdiv = !sm;
            end
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the edge
    task automatic step(input bit sm, input bit sd, input bit k);
        @(negedge clk);
        #1;
        start_mul = sm;
        start_div = sd;
        kill      = k;
        model_edge(sm, sd, k);
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".stall"}, int'(stall), 0);
        chk({tag, ".busy"}, int'(busy), 0);
        chk({tag, ".result_ready"}, int'(result_ready), 0);
        chk({tag, ".op_is_div"}, int'(op_is_div), 0);
        chk({tag, ".cycles_left"}, int'(cycles_left), 0);
    endtask

    // Asynchronous reset asserted away from the clock edge, then released
    task automatic do_reset();
        @(negedge clk);
        #2;
        mon_en    = 1'b0;
        start_mul = 1'b0;
        start_div = 1'b0;
        kill      = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        m_rem   = 0;
        m_done  = 1'b0;
        m_opdiv = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        exp_q.push_back(model_out());
        mon_en = 1'b1;
    endtask

    // Monitor: compare every cycle's outputs with the scoreboard head
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow actual=empty required=entry time=%0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("stall", int'(stall), int'(e.stall));
                chk("busy", int'(busy), int'(e.stall));
                chk("result_ready", int'(result_ready), int'(e.rr));
                chk("op_is_div", int'(op_is_div), int'(e.opdiv));
                chk("cycles_left", int'(cycles_left), e.cl);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #3;
        check_all_zero("reset_hold");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        exp_q.push_back(model_out());
        mon_en = 1'b1;

        // Multiply: full-length stall then one completion pulse
        step(1'b1, 1'b0, 1'b0);
        idle(34);
        // Divide with short latency
        step(1'b0, 1'b1, 1'b0);
        idle(6);
        // Both strobes: multiply wins
        step(1'b1, 1'b1, 1'b0);
        idle(34);
        // Kill in busy cycle 10, then kill together with start while idle
        step(1'b1, 1'b0, 1'b0);
        idle(9);
        step(1'b0, 1'b0, 1'b1);
        idle(3);
        step(1'b1, 1'b1, 1'b1);
        idle(3);
        // Start in DONE: back-to-back ops
        step(1'b0, 1'b1, 1'b0);
        idle(4);
        step(1'b1, 1'b0, 1'b0);
        idle(4);
        // Start at busy cycle 5
        step(1'b0, 1'b1, 1'b0);
        idle(40);
        // Reset in the middle of a busy period
        step(1'b1, 1'b0, 1'b0);
        idle(5);
        do_reset();
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 31) == 0);
        end
        idle(40);

        @(negedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
